// File: rtl/uib16pq_pkg.sv
// Shared constants and helpers for the uib16pq packet queue.
package uib16pq_pkg;

   // Receive FSM encoding.
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_RECV   = 2'd1;
   localparam logic [1:0] ST_COMMIT = 2'd2;

   // Bits needed to index RATIO lanes, never less than one so that
   // address fields keep a legal width.
   function automatic int clog2_min1(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/sha256.vh
// Shared definitions for the SHA-256 unit family.
// UNIT_INPUT_WIDTH : width of the narrow input stream word.
// UIB_ADDR_MSB     : MSB of the read-word index within one packet.
// MSB              : MSB of a SHA-256 datapath word.
`ifndef SHA256_VH
`define SHA256_VH
`define MSB 31
`define UNIT_INPUT_WIDTH 8
`define UIB_ADDR_MSB 4
`endif

// File: rtl/uib16pq_bram.sv
// asymm_bram_min_wr: asymmetric RAM with a narrow write port and a wide
// read port. Narrow word k of a wide word lands in bits [k*IN_WIDTH +:
// IN_WIDTH] (little-endian packing). The read register resets to zero
// and holds its value when rd_en is low.
module asymm_bram_min_wr
   import uib16pq_pkg::*;
#(
   parameter int IN_WIDTH  = 8,
   parameter int OUT_WIDTH = 16,
   parameter int RATIO     = 2,
   parameter int RD_AW     = 7,
   localparam int LANE_W   = clog2_min1(RATIO)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      wr_en,
   input  logic [RD_AW+LANE_W-1:0]   wr_addr,
   input  logic [IN_WIDTH-1:0]       din,
   input  logic                      rd_en,
   input  logic [RD_AW-1:0]          rd_addr,
   output logic [OUT_WIDTH-1:0]      dout
);

   localparam int DEPTH = 2 ** RD_AW;

   logic [OUT_WIDTH-1:0] r_mem [DEPTH];
   logic [OUT_WIDTH-1:0] r_dout;
   logic [RD_AW-1:0]     w_row;
   logic [LANE_W-1:0]    w_lane;

   assign w_row  = wr_addr[RD_AW+LANE_W-1:LANE_W];
   assign w_lane = wr_addr[LANE_W-1:0];
   assign dout   = r_dout;

   // Narrow write into one lane of the addressed wide word.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         r_mem[w_row][w_lane*IN_WIDTH +: IN_WIDTH] <= din;
      end
   end

   // Registered wide read, holding between strobes.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_dout <= '0;
      end else if (rd_en) begin
         r_dout <= r_mem[rd_addr];
      end
   end

endmodule

// File: rtl/uib16pq.sv
// uib16pq: narrow-stream to wide-read packet queue.
// An all-ones header word starts a packet of PKT_LEN*RATIO narrow words,
// which are packed into PKT_LEN wide words in one queue slot. The CPU
// reads the head packet by word index and releases it with
// set_output_complete. One slot is always kept free so full/empty can be
// told apart from the two slot pointers.
// Optional feature macro: UIB_ERR_EN enables the sticky err flag for
// IDLE-state noise words and headers dropped because the queue is full.
`include "sha256.vh"
module uib16pq
   import uib16pq_pkg::*;
#(
   parameter int IN_WIDTH      = `UNIT_INPUT_WIDTH,
   parameter int OUT_WIDTH     = 16,
   parameter int RATIO         = OUT_WIDTH / IN_WIDTH,
   parameter int PKT_LEN       = 20,
   parameter int PKT_QUEUE_MSB = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [IN_WIDTH-1:0]      din,
   input  logic                     wr_en,
   output logic                     full,
   input  logic [`UIB_ADDR_MSB:0]   rd_addr,
   input  logic                     rd_en,
   output logic [OUT_WIDTH-1:0]     dout,
   output logic                     empty,
   input  logic                     set_output_complete,
   output logic                     err
);

   localparam int QW     = PKT_QUEUE_MSB + 1;
   localparam int AW     = `UIB_ADDR_MSB + 1;
   localparam int LANE_W = clog2_min1(RATIO);
   localparam int CW     = AW + LANE_W;
   localparam logic [CW-1:0] CNT_LAST = CW'(PKT_LEN * RATIO - 1);

   logic [1:0]    r_state;
   logic [CW-1:0] r_cnt;
   logic [QW-1:0] r_base_wr;
   logic [QW-1:0] r_base_rd;
   logic          r_full;
   logic          r_empty;

   logic          w_hdr_pat;
   logic          w_hdr_ok;
   logic          w_commit;
   logic          w_release;
   logic          w_bram_we;
   logic [QW-1:0] w_base_wr_nxt;
   logic [QW-1:0] w_base_rd_nxt;
   logic [QW-1:0] w_base_wr_nxt_inc;

   assign w_hdr_pat = (din == {IN_WIDTH{1'b1}});
   assign w_hdr_ok  = (r_state == ST_IDLE) && wr_en && w_hdr_pat && !r_full;
   assign w_commit  = (r_state == ST_COMMIT);
   assign w_release = set_output_complete && !r_empty;
   assign w_bram_we = (r_state == ST_RECV) && wr_en;

   assign w_base_wr_nxt     = w_commit  ? (r_base_wr + QW'(1)) : r_base_wr;
   assign w_base_rd_nxt     = w_release ? (r_base_rd + QW'(1)) : r_base_rd;
   assign w_base_wr_nxt_inc = w_base_wr_nxt + QW'(1);

   assign full  = r_full;
   assign empty = r_empty;

   // Receive FSM and narrow-word counter; a reset aborts any partial packet.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_hdr_ok) begin
                  r_cnt   <= '0;
                  r_state <= ST_RECV;
               end
            end
            ST_RECV: begin
               if (wr_en) begin
                  r_cnt <= r_cnt + CW'(1);
                  if (r_cnt == CNT_LAST) r_state <= ST_COMMIT;
               end
            end
            ST_COMMIT: r_state <= ST_IDLE;
            default:   r_state <= ST_IDLE;
         endcase
      end
   end

   // Slot pointers and flags; flags follow the next pointer values so they
   // are valid the cycle after a commit or release.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_base_wr <= '0;
         r_base_rd <= '0;
         r_empty   <= 1'b1;
         r_full    <= 1'b0;
      end else begin
         r_base_wr <= w_base_wr_nxt;
         r_base_rd <= w_base_rd_nxt;
         r_empty   <= (w_base_wr_nxt == w_base_rd_nxt);
         r_full    <= (w_base_wr_nxt_inc == w_base_rd_nxt);
      end
   end

`ifdef UIB_ERR_EN
   logic r_err;
   assign err = r_err;

   // Sticky protocol error: noise word in IDLE or header refused while full.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_err <= 1'b0;
      end else if ((r_state == ST_IDLE) && wr_en && (!w_hdr_pat || r_full)) begin
         r_err <= 1'b1;
      end
   end
`else
   assign err = 1'b0;
`endif

   asymm_bram_min_wr #(
      .IN_WIDTH  (IN_WIDTH),
      .OUT_WIDTH (OUT_WIDTH),
      .RATIO     (RATIO),
      .RD_AW     (QW + AW)
   ) u_bram (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (w_bram_we),
      .wr_addr ({r_base_wr, r_cnt}),
      .din     (din),
      .rd_en   (rd_en),
      .rd_addr ({r_base_rd, rd_addr}),
      .dout    (dout)
   );

endmodule

// File: doc/uib16pq.md
UIB16PQ -- requirements
Module: uib16pq

Interface
REQ-001 Parameter IN_WIDTH, default `UNIT_INPUT_WIDTH (8): width of the narrow input stream word.
REQ-002 Parameter OUT_WIDTH, default 16: width of the CPU-side read word.
REQ-003 Parameter RATIO, default OUT_WIDTH/IN_WIDTH: number of input words per read word.
REQ-004 Parameter PKT_LEN, default 20: packet length in read words.
REQ-005 Parameter PKT_QUEUE_MSB, default 1: queue has 2**(PKT_QUEUE_MSB+1) slots.
REQ-006 Port clk  input  1: the single clock; all logic on posedge.
REQ-007 Port rst  input  1: reset, synchronous and active-high.
REQ-008 Port din  input  IN_WIDTH: input stream word.
REQ-009 Port wr_en  input  1: din valid this cycle.
REQ-010 Port full  output  1: no free slot; the transmitter shall not start a packet.
REQ-011 Port rd_addr  input  `UIB_ADDR_MSB+1: read-word index within the head packet.
REQ-012 Port rd_en  input  1: read strobe.
REQ-013 Port dout  output  OUT_WIDTH: read data.
REQ-014 Port empty  output  1: no completed packet in the queue.
REQ-015 Port set_output_complete  input  1: CPU has finished with the head packet; release its slot.
REQ-016 Port err  output  1: sticky protocol-error flag (see Configuration).

Function
REQ-017 The FSM shall have the states IDLE, RECV and COMMIT.
REQ-018 In IDLE, wr_en with din all-ones and full=0 shall clear the word counter and enter RECV; the header shall not be stored.
REQ-019 In IDLE, any other wr_en word shall be discarded, and the state shall stay IDLE.
REQ-020 In RECV, each wr_en shall write din to BRAM at {base_addr_wr, cnt} and increment cnt; cycles without wr_en are stalls with no state change.
REQ-021 When the write with cnt == PKT_LEN*RATIO-1 occurs, the FSM shall enter COMMIT.
REQ-022 COMMIT shall last 1 cycle: base_addr_wr += 1 (wraps modulo 2**(PKT_QUEUE_MSB+1)), then return to IDLE.
REQ-023 Packing shall be little-endian: input word k of a pair goes to dout bits [k*IN_WIDTH +: IN_WIDTH].
REQ-024 full and empty shall be registered.
  - full = (base_addr_wr+1 == base_addr_rd); usable capacity is 2**(PKT_QUEUE_MSB+1)-1 packets.
  - empty = (base_addr_wr == base_addr_rd).
  - Both update the cycle after a pointer change.
REQ-025 Last data word accepted in cycle N -> COMMIT in N+1 -> empty=0 in N+2.
REQ-026 full shall be checked only on header acceptance; a packet already in RECV completes regardless of full.
REQ-027 dout shall present the BRAM word {base_addr_rd, rd_addr} one cycle after rd_en and shall hold its value otherwise.
REQ-028 set_output_complete with empty=0 shall increment base_addr_rd; with empty=1 it shall be ignored.
REQ-029 A COMMIT and a set_output_complete in the same cycle shall both take effect; the occupancy shall be unchanged.

Reset
REQ-030 rst shall abort any partial packet and force the following; BRAM contents are don't-care:
  - state = IDLE, cnt = 0
  - base_addr_wr = 0, base_addr_rd = 0
  - empty = 1, full = 0
  - dout = 0, err = 0

Configuration
REQ-031 With UIB_ERR_EN defined, err shall set on either of these and clear only on rst:
  - a non-header wr_en word in IDLE;
  - a header arriving while full=1 (that header is dropped, and its following words are discarded as non-header).
REQ-032 Without UIB_ERR_EN, err shall be tied 0 and no error logic shall be synthesized; the discard behaviour is unchanged.

Structure
REQ-033 `UNIT_INPUT_WIDTH, `UIB_ADDR_MSB and `MSB shall be defined in the shared header sha256.vh, not locally.
REQ-034 Storage shall be one sub-module, asymm_bram_min_wr: narrow write port IN_WIDTH, wide read port OUT_WIDTH, depth 2**(PKT_QUEUE_MSB+1+`UIB_ADDR_MSB+1) read words.
REQ-035 The FSM, counter, pointers and flags shall live in uib16pq; no other sub-modules.

Verification
REQ-036 Single packet:
  - Stimulus: header 0xFF, then 40 bytes 0x00..0x27 with no stalls.
  - Response: empty=0 exactly 2 cycles after byte 0x27; rd_addr=0 -> dout=0x0100; rd_addr=19 -> dout=0x2726.
REQ-037 Stalled input:
  - Stimulus: the same packet with wr_en low every other cycle.
  - Response: identical BRAM contents; COMMIT only after the 40th byte.
REQ-038 Queue full:
  - Stimulus: send 3 packets with no reads.
  - Response: full=1; a 4th header is dropped and no slot is written; err=1 if UIB_ERR_EN, else err=0.
  - Then: one set_output_complete -> full=0 the next cycle, and a new packet is accepted.
REQ-039 Simultaneous events:
  - Stimulus: COMMIT in the same cycle as set_output_complete, with 1 packet queued.
  - Response: empty stays 0, and the head advances to the new packet.
REQ-040 Reset and idle noise:
  - Stimulus: assert rst during byte 10 of a packet.
  - Response: empty=1, full=0, err=0; a following full packet is received correctly at slot 0.
  - Stimulus: a 0x12 byte in IDLE.
  - Response: discarded; err=1 only with UIB_ERR_EN.
